// File: rtl/motor_ramp_if.sv
// motor_ramp_if: command and drive signals for one wheel.
// Master issues the software command; slave returns the ramped drive.
interface motor_ramp_if #(
   parameter int DUTY_W = 8
);
   logic [DUTY_W-1:0] tgt_duty;
   logic              tgt_dir;
   logic              tgt_en;
   logic [DUTY_W-1:0] out_duty;
   logic              out_dir;
   logic              out_en;
   logic              busy;

   modport master (
      output tgt_duty,
      output tgt_dir,
      output tgt_en,
      input  out_duty,
      input  out_dir,
      input  out_en,
      input  busy
   );

   modport slave (
      input  tgt_duty,
      input  tgt_dir,
      input  tgt_en,
      output out_duty,
      output out_dir,
      output out_en,
      output busy
   );
endinterface

// File: rtl/motor_ramp.sv
// motor_ramp: duty slew limiter with a protected reversal sequence.
// Ramp to zero, hold a dead time with the bridge off, then flip direction.
module motor_ramp #(
   parameter int DUTY_W         = 8,
   parameter int STEP           = 4,
   parameter int TICK_DIV       = 50000,
   parameter int DEADTIME_TICKS = 10
) (
   input  logic        PCLK,
   input  logic        PRESERN,
   motor_ramp_if.slave bus
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = (DEADTIME_TICKS > 1) ? $clog2(DEADTIME_TICKS) : 1;

   localparam logic [TW-1:0]     TCNT_MAX = TW'(TICK_DIV - 1);
   localparam logic [DW-1:0]     DCNT_MAX = DW'(DEADTIME_TICKS - 1);
   localparam logic [DUTY_W:0]   STEP_X   = (DUTY_W + 1)'(STEP);
   localparam logic [DUTY_W-1:0] STEP_N   = DUTY_W'(STEP);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      REV_DOWN = 2'd1,
      DEAD     = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [TW-1:0]     tcnt_q, tcnt_d;
   logic [DW-1:0]     dcnt_q, dcnt_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic              dir_q, dir_d;
   logic              en_q, en_d;

   logic              tick;
   logic [DUTY_W-1:0] eff;
   logic [DUTY_W:0]   up_sum;
   logic [DUTY_W-1:0] up_val;
   logic [DUTY_W-1:0] dn_val;
   logic [DUTY_W-1:0] seek_val;
   logic [DUTY_W-1:0] rev_val;

   // Free-running ramp tick divider
   always_comb begin
      tick   = (tcnt_q == TCNT_MAX);
      tcnt_d = tick ? '0 : tcnt_q + 1'b1;
   end

   // Step arithmetic: widened up-step clamped to target,
   // compare-before-subtract down-steps so nothing wraps
   always_comb begin
      eff    = bus.tgt_en ? bus.tgt_duty : '0;
      up_sum = {1'b0, duty_q} + STEP_X;
      up_val = (up_sum > {1'b0, eff}) ? eff : up_sum[DUTY_W-1:0];
      dn_val = eff;
      if (duty_q > eff) begin
         if ((duty_q - eff) > STEP_N) begin
            dn_val = duty_q - STEP_N;
         end
      end
      if (eff > duty_q) begin
         seek_val = up_val;
      end else if (duty_q > eff) begin
         seek_val = dn_val;
      end else begin
         seek_val = duty_q;
      end
      rev_val = (duty_q > STEP_N) ? duty_q - STEP_N : '0;
   end

   // Next-state, duty, direction and bridge enable
   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      duty_d  = duty_q;
      dir_d   = dir_q;
      unique case (state_q)
         RUN: begin
            if (tick) begin
               if (bus.tgt_dir == dir_q) begin
                  duty_d = seek_val;
               end else if (duty_q != '0) begin
                  state_d = REV_DOWN;
               end else begin
                  state_d = DEAD;
                  dcnt_d  = '0;
               end
            end
         end
         REV_DOWN: begin
            // a cancelled reversal resumes at once, tick or not
            if (bus.tgt_dir == dir_q) begin
               state_d = RUN;
            end else if (tick) begin
               duty_d = rev_val;
               if (rev_val == '0) begin
                  state_d = DEAD;
                  dcnt_d  = '0;
               end
            end
         end
         DEAD: begin
            duty_d = '0;
            if (tick) begin
               dcnt_d = dcnt_q + 1'b1;
               if (dcnt_q == DCNT_MAX) begin
                  dir_d   = bus.tgt_dir;
                  state_d = RUN;
               end
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase

      // bridge stays on while coasting down, off in dead time
      en_d = 1'b0;
      if (state_d == REV_DOWN) begin
         en_d = 1'b1;
      end else if (state_d == RUN) begin
         en_d = bus.tgt_en || (duty_d != '0);
      end
   end

   // State and output registers
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         state_q <= RUN;
         tcnt_q  <= '0;
         dcnt_q  <= '0;
         duty_q  <= '0;
         dir_q   <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         dcnt_q  <= dcnt_d;
         duty_q  <= duty_d;
         dir_q   <= dir_d;
         en_q    <= en_d;
      end
   end

   assign bus.out_duty = duty_q;
   assign bus.out_dir  = dir_q;
   assign bus.out_en   = en_q;
   assign bus.busy     = (state_q != RUN) || (duty_q != eff);

endmodule

// File: tb/tb_motor_ramp.sv
// tb_motor_ramp: directed scenarios for motor_ramp.
// STEP=16, TICK_DIV=4, DEADTIME_TICKS=2; ticks land on edges 4,8,12...
module tb_motor_ramp;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   tests = 0;
   int   fails = 0;

   motor_ramp_if #(.DUTY_W(8)) bus ();

   motor_ramp #(
      .DUTY_W(8),
      .STEP(16),
      .TICK_DIV(4),
      .DEADTIME_TICKS(2)
   ) dut (
      .PCLK(clk),
      .PRESERN(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // hold reset, apply inputs, release on a falling edge
   task automatic do_reset(input int d, input logic dir, input logic en);
      rst_n = 1'b0;
      bus.tgt_duty = d[7:0];
      bus.tgt_dir = dir;
      bus.tgt_en = en;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      bus.tgt_duty = 8'd0;
      bus.tgt_dir = 1'b0;
      bus.tgt_en = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      tests++;
      if (bus.out_duty !== 8'd0 || bus.out_dir !== 1'b0 || bus.out_en !== 1'b0) begin
         fails++;
         $display("FAIL reset_out: got d=%0d dir=%b en=%b want 0 0 0",
            bus.out_duty, bus.out_dir, bus.out_en);
      end
      tests++;
      if (bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_busy_idle: got %b want 0", bus.busy);
      end
      bus.tgt_en = 1'b1;
      bus.tgt_duty = 8'd5;
      #1;
      tests++;
      if (bus.busy !== 1'b1) begin
         fails++;
         $display("FAIL reset_busy_tgt: got %b want 1", bus.busy);
      end
   endtask

   task automatic test_ramp_up;
      do_reset(64, 1'b0, 1'b1);
      step(1);
      tests++;
      if (bus.out_en !== 1'b1 || bus.out_duty !== 8'd0) begin
         fails++;
         $display("FAIL ramp_edge1: got en=%b d=%0d want 1 0",
            bus.out_en, bus.out_duty);
      end
      step(2);
      tests++;
      if (bus.out_duty !== 8'd0) begin
         fails++;
         $display("FAIL ramp_edge3: got %0d want 0", bus.out_duty);
      end
      for (int k = 1; k <= 4; k++) begin
         step(k == 1 ? 1 : 4);
         tests++;
         if (bus.out_duty !== 8'(16 * k)) begin
            fails++;
            $display("FAIL ramp_tick%0d: got %0d want %0d",
               k, bus.out_duty, 16 * k);
         end
         tests++;
         if (bus.busy !== (k < 4)) begin
            fails++;
            $display("FAIL ramp_busy%0d: got %b want %b",
               k, bus.busy, (k < 4));
         end
      end
   endtask

   task automatic test_clamp;
      int exp_d[4] = '{48, 40, 40, 40};
      bus.tgt_duty = 8'd40;
      for (int k = 0; k < 4; k++) begin
         step(4);
         tests++;
         if (bus.out_duty !== 8'(exp_d[k])) begin
            fails++;
            $display("FAIL clamp_tick%0d: got %0d want %0d",
               k + 1, bus.out_duty, exp_d[k]);
         end
      end
      tests++;
      if (bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL clamp_busy: got %b want 0", bus.busy);
      end
   endtask

   task automatic test_disable;
      int   exp_d[4] = '{48, 32, 16, 0};
      logic exp_e[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      do_reset(64, 1'b0, 1'b1);
      step(16);
      bus.tgt_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step(4);
         tests++;
         if (bus.out_duty !== 8'(exp_d[k]) || bus.out_en !== exp_e[k]) begin
            fails++;
            $display("FAIL disable_tick%0d: got d=%0d en=%b want %0d %b",
               k + 1, bus.out_duty, bus.out_en, exp_d[k], exp_e[k]);
         end
      end
   endtask

   task automatic test_reversal;
      int   exp_d[7] = '{32, 16, 0, 0, 0, 16, 32};
      logic exp_e[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic exp_r[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic exp_b[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      do_reset(32, 1'b0, 1'b1);
      step(8);
      bus.tgt_dir = 1'b1;
      for (int k = 0; k < 7; k++) begin
         step(4);
         tests++;
         if (bus.out_duty !== 8'(exp_d[k]) || bus.out_en !== exp_e[k] ||
             bus.out_dir !== exp_r[k] || bus.busy !== exp_b[k]) begin
            fails++;
            $display("FAIL rev_tick%0d: got d=%0d en=%b dir=%b busy=%b want %0d %b %b %b",
               k + 1, bus.out_duty, bus.out_en, bus.out_dir, bus.busy,
               exp_d[k], exp_e[k], exp_r[k], exp_b[k]);
         end
      end
   endtask

   task automatic test_cancel;
      do_reset(64, 1'b0, 1'b1);
      step(8);
      bus.tgt_dir = 1'b1;
      step(4);
      tests++;
      if (bus.out_duty !== 8'd32 || bus.busy !== 1'b1) begin
         fails++;
         $display("FAIL cancel_enter: got d=%0d busy=%b want 32 1",
            bus.out_duty, bus.busy);
      end
      step(4);
      tests++;
      if (bus.out_duty !== 8'd16) begin
         fails++;
         $display("FAIL cancel_down: got %0d want 16", bus.out_duty);
      end
      step(2);
      bus.tgt_dir = 1'b0;
      step(1);
      tests++;
      if (bus.out_duty !== 8'd16 || bus.out_en !== 1'b1) begin
         fails++;
         $display("FAIL cancel_hold: got d=%0d en=%b want 16 1",
            bus.out_duty, bus.out_en);
      end
      step(1);
      tests++;
      if (bus.out_duty !== 8'd32 || bus.out_dir !== 1'b0) begin
         fails++;
         $display("FAIL cancel_resume: got d=%0d dir=%b want 32 0",
            bus.out_duty, bus.out_dir);
      end
      step(4);
      tests++;
      if (bus.out_duty !== 8'd48) begin
         fails++;
         $display("FAIL cancel_next: got %0d want 48", bus.out_duty);
      end
   endtask

   task automatic test_async_reset;
      do_reset(16, 1'b0, 1'b1);
      step(4);
      bus.tgt_dir = 1'b1;
      step(16);
      tests++;
      if (bus.out_dir !== 1'b1 || bus.out_en !== 1'b1 || bus.out_duty !== 8'd0) begin
         fails++;
         $display("FAIL async_pre: got dir=%b en=%b d=%0d want 1 1 0",
            bus.out_dir, bus.out_en, bus.out_duty);
      end
      step(4);
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (bus.out_duty !== 8'd0 || bus.out_dir !== 1'b0 || bus.out_en !== 1'b0) begin
         fails++;
         $display("FAIL async_run: got d=%0d dir=%b en=%b want 0 0 0",
            bus.out_duty, bus.out_dir, bus.out_en);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(6);
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (bus.out_duty !== 8'd0 || bus.out_dir !== 1'b0 || bus.out_en !== 1'b0) begin
         fails++;
         $display("FAIL async_dead: got d=%0d dir=%b en=%b want 0 0 0",
            bus.out_duty, bus.out_dir, bus.out_en);
      end
      bus.tgt_dir = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(3);
      tests++;
      if (bus.out_duty !== 8'd0) begin
         fails++;
         $display("FAIL async_edge3: got %0d want 0", bus.out_duty);
      end
      step(1);
      tests++;
      if (bus.out_duty !== 8'd16) begin
         fails++;
         $display("FAIL async_edge4: got %0d want 16", bus.out_duty);
      end
   endtask

   task automatic test_saturate;
      do_reset(255, 1'b0, 1'b1);
      step(60);
      tests++;
      if (bus.out_duty !== 8'd240) begin
         fails++;
         $display("FAIL sat_240: got %0d want 240", bus.out_duty);
      end
      step(4);
      tests++;
      if (bus.out_duty !== 8'd255 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL sat_255: got d=%0d busy=%b want 255 0",
            bus.out_duty, bus.busy);
      end
      step(4);
      tests++;
      if (bus.out_duty !== 8'd255) begin
         fails++;
         $display("FAIL sat_hold: got %0d want 255", bus.out_duty);
      end
   endtask

   initial begin
      test_reset;
      test_ramp_up;
      test_clamp;
      test_disable;
      test_reversal;
      test_cancel;
      test_async_reset;
      test_saturate;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/motor_ramp.md
# motor_ramp

Slew-rate limiter and reversal sequencer between the APB register block and the per-wheel `pwm_gen` / `dir_sel` pair. It takes the software-commanded duty, direction and enable for one wheel and produces a ramped duty, a protected direction and an enable. Duty never jumps by more than `STEP` per ramp tick. Direction never flips while the motor is driven: a reversal ramps to zero, holds a dead time with the bridge disabled, then switches direction. One instance is used per wheel.

## Interface
- `DUTY_W`, 8: width of the duty words.
- `STEP`, 4: maximum duty change per ramp tick; range 1..2^DUTY_W-1.
- `TICK_DIV`, 50000: `PCLK` cycles per ramp tick; must be at least 1.
- `DEADTIME_TICKS`, 10: ramp ticks spent in dead time on reversal; must be at least 1.
- `PCLK`  in  1  fabric clock; the same clock that drives `pwm_gen` / `dir_sel`.
- `PRESERN`  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `tgt_duty`  in  DUTY_W  commanded duty from the APB register.
- `tgt_dir`  in  1  commanded direction.
- `tgt_en`  in  1  commanded enable.
- `out_duty`  out  DUTY_W  ramped duty to `pwm_gen`; registered.
- `out_dir`  out  1  protected direction to `dir_sel`; registered.
- `out_en`  out  1  bridge enable to `dir_sel`; registered.
- `busy`  out  1  combinational. High when state ≠ RUN, or when `out_duty` ≠ the effective target.

## Operation
- Effective target `eff` = `tgt_en` ? `tgt_duty` : 0.
- Tick generator:
  - Counter `tcnt` of width clog2(TICK_DIV), minimum 1 bit.
  - `tick` = (`tcnt` == TICK_DIV-1). On `tick`, `tcnt` wraps to 0; otherwise it increments.
  - When TICK_DIV = 1, `tick` is high every cycle.
  - The tick generator runs free in all states.
- FSM states: RUN, REV_DOWN, DEAD. The reset state is RUN.
- RUN, on `tick`:
  - If `tgt_dir` == `out_dir`: move `out_duty` toward `eff` by min(STEP, |eff − out_duty|). No overshoot.
  - If `tgt_dir` ≠ `out_dir` and `out_duty` > 0: go to REV_DOWN. `out_duty` is left unchanged on this tick.
  - If `tgt_dir` ≠ `out_dir` and `out_duty` == 0: go to DEAD and clear `dcnt`.
- REV_DOWN:
  - On any cycle where `tgt_dir` == `out_dir`, return to RUN on the next edge. This check is not tick-gated and takes priority.
  - Otherwise, on `tick`, `out_duty` = max(out_duty − STEP, 0). When the result is 0, go to DEAD and clear `dcnt`.
- DEAD:
  - `out_duty` holds 0.
  - `dcnt` increments on each `tick`.
  - On the tick where `dcnt` == DEADTIME_TICKS-1: load `out_dir` ← `tgt_dir` as sampled on that edge, then go to RUN.
  - DEAD is never aborted. A `tgt_dir` change during DEAD is absorbed by the final sample.
- Arithmetic:
  - Up-steps are computed in DUTY_W+1 bits and clamped to `eff`. The maximum result is 2^DUTY_W-1.
  - Down-steps are computed as a comparison before the subtraction, so they never underflow.
- `out_en` is registered and updated every edge.
  - Next value is 1 when the next state is REV_DOWN.
  - Next value is 1 when the next state is RUN and (`tgt_en` or next `out_duty` ≠ 0).
  - Otherwise the next value is 0.
  - The bridge therefore stays enabled while ramping down after `tgt_en` falls, and is disabled in DEAD.
- `out_dir` changes only on the DEAD→RUN edge.

## Timing
- Reset (`PRESERN` low, asynchronous):
  - `out_duty` = 0, `out_dir` = 0, `out_en` = 0.
  - `tcnt` = 0, `dcnt` = 0, state = RUN.
  - `busy` follows its combinational definition.
- First tick after reset release: on the TICK_DIV-th rising edge.
- Duty latency: `out_duty` changes on the tick edge itself. Inputs are sampled on that same edge; there is no input pipeline.
- Reset asserted mid-ramp or mid-dead-time: outputs go to reset values immediately, without waiting for a clock. After release, operation restarts in RUN with `out_dir` = 0.
- Inputs are synchronous to `PCLK`; no synchronizers are included.

## Test plan
Parameters for all scenarios: DUTY_W=8, STEP=16, TICK_DIV=4, DEADTIME_TICKS=2. Edges are counted after reset release.
- Ramp up from reset:
  - Stimulus: `tgt_en`=1, `tgt_duty`=64, `tgt_dir`=0.
  - Response: `out_duty` = 16, 32, 48, 64 at edges 4, 8, 12, 16. `out_en` = 1 from edge 1. `busy` low after edge 16.
- Clamped ramp down:
  - Stimulus: from 64, set `tgt_duty`=40.
  - Response: next tick gives 48, the following tick gives 40 (clamped). Stays at 40 with no oscillation.
- Disable:
  - Stimulus: from 64, set `tgt_en`=0.
  - Response: `out_duty` = 48, 32, 16, 0 on successive ticks. `out_en` is 1 through 16 and falls on the same edge where `out_duty` becomes 0.
- Reversal:
  - Stimulus: at 32 with dir 0, set `tgt_dir`=1.
  - Response:
    - tick 1: enter REV_DOWN, duty 32.
    - tick 2: duty 16.
    - tick 3: duty 0, enter DEAD, `out_en`=0.
    - ticks 4–5: dead time; on tick 5, `out_dir`=1 and `out_en`=1.
    - Then ramps 16, 32.
- Reversal cancelled:
  - Stimulus: in REV_DOWN at 16, return `tgt_dir` to 0 mid-tick-period.
  - Response: state is RUN one edge later. The next tick gives 32, and `out_dir` stays 0.
- Asynchronous reset mid-DEAD:
  - Stimulus: drop `PRESERN` between clock edges.
  - Response: `out_en`, `out_duty` and `out_dir` are 0 before the next edge. After release, the first tick is at edge 4.
